// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, synchronous-read word memory between
// instruction fetch (IF, read-only) and the load/store unit (LS, read/write
// with byte enables).
//
// Arbitration is round-robin on conflict. LS can hold the bus across several
// accesses (read-modify-write) with ls_lock. Grants and memory-side signals
// are combinational from the requests. The completion (rvalid/rdata) for a
// grant appears the following cycle, so a grant can be issued every cycle.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   if_req/if_addr             IF read request and word address
//   if_gnt                     IF accepted this cycle
//   if_rvalid/if_rdata         IF read data, cycle after grant
//   ls_req/ls_we/ls_be         LS request, write flag, byte enables
//   ls_addr/ls_wdata/ls_lock   LS word address, write data, keep-bus flag
//   ls_gnt                     LS accepted this cycle
//   ls_rvalid/ls_rdata         LS completion (read data, or 0 for write ack)
//   mem_en/we/be/addr/wdata    memory command, driven by the granted side
//   mem_rdata                  memory read data, cycle after mem_en
//   conflict_cnt               saturating count of cycles with both requesting

// Per-requester completion port. rdata shows the memory data (reads) or zero
// (write acks) in the completion cycle and otherwise holds the last value.
module dmem_arbiter_rsp #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpl,
    input  logic          cpl_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    rdata_q <= '0;
        else if (cpl) rdata_q <= rdata;
    end

    assign rvalid = cpl;
    assign rdata  = cpl ? (cpl_we ? '0 : mem_rdata) : rdata_q;
endmodule

module dmem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [3:0]    ls_be,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic          ls_lock,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);
    localparam int NREQ   = 2;
    localparam int REQ_IF = 0;
    localparam int REQ_LS = 1;

    typedef enum logic {ARB, LOCKED} state_t;

    // One in-flight access: who owns the completion and whether it was a write.
    typedef struct packed {
        logic valid;
        logic owner;
        logic we;
    } pend_t;

    state_t        state;
    logic          last_gnt;   // 1 = LS was granted last
    pend_t         pend;
    logic [CW-1:0] conflict_q;
    logic          if_gnt_c, ls_gnt_c;

    // A locked LS owns the bus only while it keeps requesting; once it drops
    // ls_req the normal arbitration applies in that same cycle.
    always_comb begin
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        if (state == LOCKED && ls_req) begin
            ls_gnt_c = 1'b1;
        end else if (if_req && ls_req) begin
            ls_gnt_c = (last_gnt == 1'(REQ_IF));
            if_gnt_c = ~ls_gnt_c;
        end else begin
            if_gnt_c = if_req;
            ls_gnt_c = ls_req;
        end
    end

    assign if_gnt = if_gnt_c;
    assign ls_gnt = ls_gnt_c;

    // Memory command from the granted side. IF can only read; LS reads use
    // all byte lanes.
    assign mem_en    = if_gnt_c | ls_gnt_c;
    assign mem_we    = ls_gnt_c & ls_we;
    assign mem_be    = ls_gnt_c ? (ls_we ? ls_be : 4'hF) : 4'h0;
    assign mem_addr  = ls_gnt_c ? ls_addr : (if_gnt_c ? if_addr : '0);
    assign mem_wdata = (ls_gnt_c & ls_we) ? ls_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            last_gnt   <= 1'(REQ_IF);
            pend       <= '0;
            conflict_q <= '0;
        end else begin
            state <= (ls_gnt_c && ls_lock) ? LOCKED : ARB;

            if (ls_gnt_c)      last_gnt <= 1'(REQ_LS);
            else if (if_gnt_c) last_gnt <= 1'(REQ_IF);

            pend.valid <= if_gnt_c | ls_gnt_c;
            pend.owner <= ls_gnt_c;
            pend.we    <= ls_gnt_c & ls_we;

            if (if_req && ls_req && conflict_q != {CW{1'b1}})
                conflict_q <= conflict_q + 1'b1;
        end
    end

    assign conflict_cnt = conflict_q;

    logic [NREQ-1:0]         rvalid_v;
    logic [NREQ-1:0][DW-1:0] rdata_v;

    for (genvar r = 0; r < NREQ; r++) begin : g_rsp
        dmem_arbiter_rsp #(.DW(DW)) u_rsp (
            .clk       (clk),
            .reset     (reset),
            .cpl       (pend.valid && pend.owner == 1'(r)),
            .cpl_we    (pend.we),
            .mem_rdata (mem_rdata),
            .rvalid    (rvalid_v[r]),
            .rdata     (rdata_v[r])
        );
    end

    assign if_rvalid = rvalid_v[REQ_IF];
    assign if_rdata  = rdata_v[REQ_IF];
    assign ls_rvalid = rvalid_v[REQ_LS];
    assign ls_rdata  = rdata_v[REQ_LS];
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port, synchronous-read word memory between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write with byte enables).
- Round-robin arbitration with a lock for LS read-modify-write sequences.
- 1-cycle read latency, one access per cycle, fully pipelined.
- Sits between the core's fetch/LSU paths and the shared memory macro, replacing separate instruction and data memories.

Parameters:
AW, 10, word-address width (1024 words)
DW, 32, data width
CW, 16, conflict-counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
if_req  input  1  IF read request
if_addr  input  AW  IF word address
if_gnt  output  1  IF request accepted this cycle (combinational)
if_rvalid  output  1  IF read data valid (cycle after grant)
if_rdata  output  DW  IF read data
ls_req  input  1  LS request
ls_we  input  1  LS write
ls_be  input  4  LS byte enables (writes)
ls_addr  input  AW  LS word address
ls_wdata  input  DW  LS write data
ls_lock  input  1  keep bus for LS after this access
ls_gnt  output  1  LS request accepted (combinational)
ls_rvalid  output  1  LS completion; read data valid or write ack
ls_rdata  output  DW  LS read data
mem_en  output  1  memory access enable
mem_we  output  1  memory write
mem_be  output  4  memory byte enables
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data (valid cycle after mem_en)
conflict_cnt  output  CW  saturating count of cycles where both requested

Behaviour:
- Reset (async, active-high):
  - state=ARB, last_gnt=IF, pending_valid=0, conflict_cnt=0.
  - if_rvalid, ls_rvalid = 0; rdata outputs = 0.
  - Combinational outputs follow the reset state: gnts=0 with no requests.
- Requester handshake:
  - Request is held (address/data stable) until gnt=1 in the same cycle.
  - Exactly one gnt per cycle at most.
  - Memory outputs are driven combinationally from the granted requester.
  - When no grant: mem_en=0, mem_we=0, mem_be=0.
- States:
  - ARB:
    - Only one requester active → that requester is granted.
    - Both active → grant the one not equal to last_gnt.
    - last_gnt updates on every grant.
    - LS granted with ls_lock=1 → LOCKED next cycle.
  - LOCKED:
    - if_gnt forced 0; LS granted whenever ls_req=1.
    - LS granted with ls_lock=0 → ARB.
    - ls_req=0 → ARB immediately in the same cycle (IF may be granted that cycle).
- IF writes are impossible: IF grant drives mem_we=0, mem_be=0.
- LS reads drive mem_be=4'hF.
- Completion:
  - Registered pending_valid/pending_owner/pending_we capture each grant.
  - Next cycle, the owner's rvalid=1 for exactly one cycle.
  - For reads, rdata=mem_rdata. For writes, rdata=0.
  - The non-owner's rvalid=0 and its rdata holds its last value.
- Back-to-back: grant every cycle is allowed; completion of cycle T overlaps grant in cycle T+1.
- conflict_cnt:
  - Increments in any cycle with if_req=1 and ls_req=1, including in LOCKED.
  - Saturates at 2^CW-1; no wrap.
- Reset mid-operation: the pending completion is discarded; no rvalid after reset deasserts.
- Latency: 1 cycle request→data with no contention. With contention, the loser waits 1 cycle, or until the lock is released.

Test Plan:
- Reset, then if_req=1, if_addr=3, mem[3]=32'h00100093 → if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=32'h00100093; conflict_cnt=0.
- LS write ls_addr=5, ls_be=4'b0011, ls_wdata=32'hAABBCCDD over mem[5]=0, then LS read addr 5 → write ack ls_rvalid=1 with ls_rdata=0; read returns 32'h0000CCDD.
- Both requesting continuously for 4 cycles after reset → grants alternate LS, IF, LS, IF; conflict_cnt=4; each rvalid is routed to the correct owner.
- LS with ls_lock=1 for 3 grants then ls_lock=0 while if_req=1 throughout → if_gnt=0 for 4 cycles, then if_gnt=1; conflict_cnt counts all 5 cycles.
- Assert reset the cycle after an LS read grant → ls_rvalid stays 0; state=ARB; conflict_cnt=0.
- CW=4, both requesting for 20 cycles → conflict_cnt reaches 15 and holds.
